// File: rtl/avalon_hex_to_seg_de1soc_pkg.sv
// Shared constants and types for the six-digit hex display block.
// Pattern table is active-low, bit0=a .. bit6=g.
package avalon_hex_to_seg_de1soc_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int SEG_W      = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   localparam logic [SEG_W-1:0] SEG_PAT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct packed {
      logic       en;
      logic [3:0] digit;
   } digit_reg_t;

endpackage

// File: rtl/avalon_hex_to_seg_de1soc_hex_to_seg.sv
// Combinational hex digit to active-low 7-segment decode, blanked when disabled.
// Zero latency; no flow control.
module hex_to_seg
   import avalon_hex_to_seg_de1soc_pkg::*;
(
   input  logic [3:0]       i_digit,
   input  logic             i_enable,
   output logic [SEG_W-1:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (i_enable) begin
         o_seg = SEG_PAT[i_digit];
      end
   end

endmodule

// File: rtl/avalon_hex_to_seg_de1soc.sv
// Avalon-MM write-only slave holding six digit registers that drive HEX0..HEX5.
// Display updates one edge after the write; accepts a write every cycle, never stalls.
module avalon_hex_to_seg_de1soc
   import avalon_hex_to_seg_de1soc_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [2:0]                       avms_address_i,
   input  logic                             avms_write_i,
   input  logic [7:0]                       avms_writedata_i,
   output logic [NUM_DIGITS-1:0][SEG_W-1:0] segment_symbol_o
);

   digit_reg_t r_digits [NUM_DIGITS];
   digit_reg_t w_wr_reg;
   logic       w_unused_bits;

   assign w_wr_reg      = {avms_writedata_i[5], avms_writedata_i[3:0]};
   // Bits 4 and 7:6 carry no meaning on this slave.
   assign w_unused_bits = ^{avms_writedata_i[7:6], avms_writedata_i[4]};

   // Addresses 6 and 7 match no register and so fall through as no-ops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_digits[i] <= '0;
         end
      end else if (avms_write_i) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (avms_address_i == 3'(i)) begin
               r_digits[i] <= w_wr_reg;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      hex_to_seg u_dec (
         .i_digit  (r_digits[g].digit),
         .i_enable (r_digits[g].en),
         .o_seg    (segment_symbol_o[g])
      );
   end

endmodule

// File: tb/tb_avalon_hex_to_seg_de1soc.sv
// Randomised and directed bench for the hex display slave against a register-array model.
module tb_avalon_hex_to_seg_de1soc;

   localparam logic [6:0] PAT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [2:0]      addr = '0;
   logic            wr = 1'b0;
   logic [7:0]      wdata = '0;
   logic [5:0][6:0] seg;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Model state: per display, enable flag and hex value.
   bit       m_en  [6];
   int       m_val [6];

   avalon_hex_to_seg_de1soc dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .avms_address_i   (addr),
      .avms_write_i     (wr),
      .avms_writedata_i (wdata),
      .segment_symbol_o (seg)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] model_seg(int n);
      return m_en[n] ? PAT[m_val[n]] : 7'h7F;
   endfunction

   // Drive one cycle's inputs, advance past the edge, then apply the same
   // transaction to the model.
   task automatic step(input bit r, input bit w, input int a, input int d);
      logic [7:0] dd;
      rst_n = r; wr = w; addr = 3'(a); wdata = 8'(d);
      dd = 8'(d);
      @(posedge clk);
      if (!r) begin
         for (int i = 0; i < 6; i++) begin
            m_en[i] = 1'b0; m_val[i] = 0;
         end
      end else if (w && a < 6) begin
         m_en[a]  = dd[5];
         m_val[a] = int'(dd[3:0]);
      end
      #1;
   endtask

   task automatic check_lit(input string name, input int n, input logic [6:0] exp);
      n_checks++;
      if (seg[n] !== exp) begin
         n_errors++;
         $display("FAIL %s HEX%0d got %h want %h", name, n, seg[n], exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (seg[i] !== model_seg(i)) begin
               n_errors++;
               $display("FAIL model HEX%0d t=%0t got %h want %h", i, $time, seg[i], model_seg(i));
            end
         end
      end
   end

   initial begin
      logic [6:0] pat_a [8];
      int         dat_a [8];
      logic [6:0] after_a [6];

      for (int i = 0; i < 5; i++) step(0, i[0], i, 8'h2F);
      chk_en = 1'b1;
      for (int i = 0; i < 6; i++) check_lit("reset", i, 7'h7F);

      // Digits 0..5 enabled, idle gaps between writes.
      for (int i = 0; i < 6; i++) begin
         step(1, 1, i, 8'h20 + i);
         check_lit("write_latency", i, PAT[i]);
         for (int k = 0; k < 5; k++) step(1, 0, i, 8'h2F);
      end
      check_lit("hold0", 0, 7'h40); check_lit("hold1", 1, 7'h79);
      check_lit("hold2", 2, 7'h24); check_lit("hold3", 3, 7'h30);
      check_lit("hold4", 4, 7'h19); check_lit("hold5", 5, 7'h12);

      dat_a = '{8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E, 8'h2F, 8'h05, 8'hF8};
      pat_a = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h7F, 7'h00};
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 0, dat_a[i]);
         check_lit("addr0_decode", 0, pat_a[i]);
      end

      after_a = '{7'h00, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
      step(1, 1, 6, 8'h28);
      step(1, 1, 7, 8'h28);
      for (int i = 0; i < 6; i++) check_lit("ignored_addr", i, after_a[i]);

      for (int k = 0; k < 10; k++) step(1, 0, $urandom_range(0, 7), $urandom_range(0, 255));
      for (int i = 0; i < 6; i++) check_lit("no_write", i, after_a[i]);

      step(0, 1, 3, 8'h27);
      for (int i = 0; i < 6; i++) check_lit("reset_vs_write", i, 7'h7F);
      step(1, 0, 3, 8'h27);
      check_lit("reset_release", 3, 7'h7F);

      // Back-to-back writes, last one wins.
      step(1, 1, 2, 8'h21);
      step(1, 1, 2, 8'h2D);
      check_lit("last_wins", 2, 7'h21);

      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 7), $urandom_range(0, 255));
      end

      step(1, 0, 0, 0);
      chk_en = 1'b0;
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/avalon_hex_to_seg_de1soc.md
AVALON_HEX_TO_SEG_DE1SOC -- requirements
Module: avalon_hex_to_seg_de1soc

Interface
REQ-001 Parameters: none; digit count (6) and segment width (7) SHALL be package constants.
REQ-002 There SHALL be one clock; reset is synchronous and active-low. Clock port is clk and reset port is rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 avms_address_i  input  3  Avalon-MM slave word address selecting digit register 0..5.
REQ-006 avms_write_i  input  1  Avalon-MM write strobe; a write is accepted on any rising clk edge where it is 1.
REQ-007 avms_writedata_i  input  8  write data: [3:0] hex digit, [5] digit enable, [4] and [7:6] ignored.
REQ-008 segment_symbol_o  output  [5:0][6:0]  packed array; element n drives HEXn; bit0=a .. bit6=g; active-low (0 = segment lit).
REQ-009 The module SHALL have no read port, no waitrequest and no other ports.

Function
REQ-010 The block SHALL hold six 5-bit digit registers, one per display, each storing {enable, digit[3:0]}.
REQ-011 On a rising clk edge with rst_n=1, avms_write_i=1 and avms_address_i=n (n<=5), register n SHALL load {writedata[5], writedata[3:0]}; the other registers SHALL hold their values.
REQ-012 Writes to address 6 or 7 SHALL be ignored with no state change.
REQ-013 With avms_write_i=0, all registers SHALL hold their values regardless of address and data.
REQ-014 segment_symbol_o[n] SHALL be a combinational decode of register n, so the new pattern is visible immediately after the accepting edge (1-cycle write-to-display latency, no additional pipeline).
REQ-015 If enable=0, segment_symbol_o[n] SHALL be 7'h7F (all segments off).
REQ-016 If enable=1, the active-low patterns SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
REQ-017 Back-to-back writes on consecutive cycles SHALL each be accepted; repeated writes to the same address SHALL keep the last value.
REQ-018 The block SHALL accept writes every cycle with no backpressure.

Reset
REQ-019 While rst_n=0 at a rising edge, all six registers SHALL clear to 0 (enable=0, digit=0), so every segment_symbol_o[n] = 7'h7F.
REQ-020 Reset SHALL take priority over a simultaneous write; that write is lost.
REQ-021 Reset asserted mid-operation SHALL blank all displays at the next rising edge; rst_n SHALL NOT act asynchronously.

Structure
REQ-022 A shared package SHALL hold NUM_DIGITS=6, SEG_W=7, SEG_BLANK=7'h7F, the 16-entry segment pattern constants, and a typedef for the 5-bit digit register.
REQ-023 A purely combinational sub-module hex_to_seg (4-bit digit plus enable in, 7-bit active-low pattern out) SHALL be instantiated six times by a generate loop.
REQ-024 All sequential logic SHALL use a single always_ff on posedge clk only.

Verification
REQ-025 Hold rst_n=0 for 5 cycles -> all six segment_symbol_o elements = 7F.
REQ-026 After reset, write 0x20..0x25 to addresses 0..5, with 5 idle cycles between writes -> HEX0..HEX5 = 40,79,24,30,19,12, each valid on the edge after its write and unchanged afterwards.
REQ-027 Write 0x2A/0x2B/0x2C/0x2D/0x2E/0x2F to address 0 -> 08,03,46,21,06,0E; write 0x05 to address 0 -> 7F (enable=0); write 0xF8 to address 0 -> 00 (bits 7:6 and 4 ignored).
REQ-028 Write to addresses 6 and 7 with data 0x28 -> no element changes.
REQ-029 Assert rst_n=0 in the same cycle as a write of 0x27 to address 3 -> all elements = 7F and HEX3 stays 7F after reset is released.
REQ-030 Hold avms_write_i=0 while toggling address and data for 10 cycles -> outputs unchanged.
